fixed_integer_matrix_dot_vector: RTL and testbench
==================================================

FIXED_INTEGER_MATRIX_DOT_VECTOR -- requirements
Module: fixed_integer_matrix_dot_vector

Interface
REQ-001 SHALL have parameter BITS, default 16, operand/result word width.
REQ-002 SHALL have parameter LENGTH, default 10, elements per vector; LENGTH % MULTS == 0.
REQ-003 SHALL have parameter MULTS, default 2, elements accepted per beat.
REQ-004 SHALL have parameter NEURONS, default 4, stored weight rows computed in parallel.
REQ-005 SHALL have parameter SATURATE, default 0, 1 = signed saturation of results, 0 = wrap.
REQ-006 SHALL have one clock and asynchronous active-low reset, listed first:
- clk  input  1  sole clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
REQ-007 SHALL have the following data and control ports:
- in_valid  input  1  vector_b beat valid.
- load_a  input  1  weight load beat valid.
- vector_a_in  input  BITS x MULTS  weight words.
- vector_b  input  BITS x MULTS  input vector chunk.
- out_valid  output  1  one-cycle result strobe.
- c  output  BITS x NEURONS  results, row r in c[r].

Function
REQ-008 SHALL hold NEURONS*LENGTH weights in a shift store; each load_a beat shifts by MULTS and writes vector_a_in[m] to flat index m.
REQ-009 SHALL map flat index i to row i/LENGTH, element i%LENGTH; after N_LOAD = NEURONS*LENGTH/MULTS beats, beat j (0-based) occupies flat indices (N_LOAD-1-j)*MULTS+m.
REQ-010 SHALL treat all operands as signed two's complement; products 2*BITS wide; accumulators ACC_BITS = 2*BITS + clog2(LENGTH), no internal overflow.
REQ-011 SHALL keep beat counter 0..LENGTH/MULTS-1; an accepted in_valid beat at count k multiplies vector_b[m] by element k*MULTS+m of every row; the counter wraps to 0 after the last beat.
REQ-012 SHALL register products at the accepting edge (stage 1) and accumulate at the next edge (stage 2).
REQ-013 SHALL, for the last beat accepted at edge T, register c and raise out_valid at edge T+1, held for exactly one cycle.
REQ-014 SHALL, when SATURATE=0, output the low BITS of each accumulator; when SATURATE=1, clamp to [-2^(BITS-1), 2^(BITS-1)-1].
REQ-015 SHALL hold c at its last value between strobes.
REQ-016 SHALL accept back-to-back vectors with no idle cycle; the first beat of the next vector starts a fresh accumulation, not a sum with the previous one.
REQ-017 SHALL give load_a priority when load_a and in_valid are high together: the in_valid beat is dropped.
REQ-018 SHALL, on any load_a beat, reset the counter to 0 and discard a partial vector, including products in flight; no out_valid is produced for it.
REQ-019 SHALL keep the weights unchanged when load_a is low.

Reset
REQ-020 SHALL, on rstn low, asynchronously clear out_valid, c, the counter, stage-1 registers and accumulators to 0.
REQ-021 SHALL reset weights to 0.
REQ-022 SHALL discard an in-progress vector when reset is applied mid-vector.

Structure
REQ-023 SHALL put ACC_BITS computation and saturation/truncation function in shared package fixed_integer_nn_pkg.
REQ-024 SHALL instantiate one sub-module integer_mac_row per neuron; it contains the MULTS multipliers, the adder tree, the accumulator and the output clamp.

Verification (BITS=16, LENGTH=4, MULTS=2, NEURONS=2)
REQ-025 SHALL check reset: after rstn low, out_valid=0 and c={0,0} with no clock running.
REQ-026 SHALL check a basic vector: load row0=[1,2,3,4], row1=[-1,0,1,2], then beats [5,6],[7,8] -> c={70,18}, out_valid one cycle, one edge after the beat-2 edge.
REQ-027 SHALL check back-to-back vectors: [5,6],[7,8],[1,1],[1,1] on consecutive cycles -> strobes {70,18} then {10,2}, consecutive pairs two cycles apart.
REQ-028 SHALL check overflow: all weights and inputs 32767 -> SATURATE=1 gives c={32767,32767}; SATURATE=0 gives c={4,4}.
REQ-029 SHALL check abort by load: beat [5,6], then load_a together with in_valid -> no out_valid; the next full vector uses a counter restarted at 0.
REQ-030 SHALL check reset mid-vector: rstn pulsed after beat 1 -> no strobe; outputs 0; weights 0 until reloaded.

Source files
------------

// File: rtl/fixed_integer_nn_pkg.sv
// Shared definitions for the fixed-point integer neural-network blocks.
//   beat_ctl_t    : stage-1 control tag travelling alongside the registered products
//   acc_bits()    : accumulator width that cannot overflow for a LENGTH-term signed dot product
//   clamp_or_wrap(): final narrowing of an accumulator to the output word width
package fixed_integer_nn_pkg;

    // Working width for the narrowing helper; accumulators are sign-extended into it.
    localparam int SAT_W = 128;

    typedef struct packed {
        logic valid;   // a beat was accepted on the previous edge
        logic first;   // that beat opens a new vector
        logic last;    // that beat closes the vector
    } beat_ctl_t;

    function automatic int acc_bits(input int bits, input int length);
        return 2 * bits + $clog2(length);
    endfunction

    // Saturating mode clamps to the signed range of 'bits'; wrapping mode passes the
    // value through and the caller keeps only the low 'bits' bits.
    function automatic logic signed [SAT_W-1:0] clamp_or_wrap(
        input logic signed [SAT_W-1:0] acc,
        input int                      bits,
        input logic                    saturate
    );
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        logic signed [SAT_W-1:0] res;
        max_v = (128'sd1 <<< (bits - 1)) - 128'sd1;
        min_v = -(128'sd1 <<< (bits - 1));
        if (!saturate) begin
            res = acc;
        end else if (acc > max_v) begin
            res = max_v;
        end else if (acc < min_v) begin
            res = min_v;
        end else begin
            res = acc;
        end
        return res;
    endfunction

endpackage

// File: rtl/integer_mac_row.sv
// One neuron row: MULTS signed multipliers, adder tree, accumulator and output narrowing.
// Ports:
//   clk, rstn    : clock and asynchronous active-low reset
//   accept       : a vector_b beat is taken on this edge (products are registered)
//   beat_idx     : position of the current beat inside the vector
//   ctl          : stage-1 tag for the products currently held
//   row_weights  : LENGTH weights of this row, element e at [e*BITS +: BITS]
//   vector_b     : MULTS input elements of the current beat
//   c_row        : registered row result, updated only when a vector completes
module integer_mac_row
    import fixed_integer_nn_pkg::*;
#(
    parameter int BITS     = 16,
    parameter int LENGTH   = 10,
    parameter int MULTS    = 2,
    parameter int SATURATE = 0,
    parameter int CNT_W    = 3
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     accept,
    input  logic [CNT_W-1:0]         beat_idx,
    input  beat_ctl_t                ctl,
    input  logic [LENGTH*BITS-1:0]   row_weights,
    input  logic [MULTS*BITS-1:0]    vector_b,
    output logic [BITS-1:0]          c_row
);

    localparam int ACC_BITS  = acc_bits(BITS, LENGTH);
    localparam int PROD_BITS = 2 * BITS;
    localparam int BEAT_BITS = MULTS * BITS;

    logic [BEAT_BITS-1:0]        w_chunk_s;
    logic signed [PROD_BITS-1:0] prod_r [MULTS];
    logic signed [ACC_BITS-1:0]  psum_s;
    logic signed [ACC_BITS-1:0]  acc_next_s;
    logic signed [ACC_BITS-1:0]  acc_r;
    logic [BITS-1:0]             c_next_s;
    logic [BITS-1:0]             c_r;

    // Select the MULTS weights that pair with the elements of the current beat.
    always_comb begin
        w_chunk_s = BEAT_BITS'(row_weights >> (32'(beat_idx) * 32'(BEAT_BITS)));
    end

    // Stage 1: register the signed products of the accepted beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int m = 0; m < MULTS; m++) begin
                prod_r[m] <= '0;
            end
        end else if (accept) begin
            for (int m = 0; m < MULTS; m++) begin
                prod_r[m] <= PROD_BITS'($signed(w_chunk_s[m*BITS +: BITS]))
                           * PROD_BITS'($signed(vector_b[m*BITS +: BITS]));
            end
        end else begin
            for (int m = 0; m < MULTS; m++) begin
                prod_r[m] <= prod_r[m];
            end
        end
    end

    // Adder tree plus accumulation; a first beat restarts the sum instead of adding to it.
    always_comb begin
        psum_s = '0;
        for (int m = 0; m < MULTS; m++) begin
            psum_s = psum_s + ACC_BITS'(prod_r[m]);
        end
        if (ctl.first) begin
            acc_next_s = psum_s;
        end else begin
            acc_next_s = acc_r + psum_s;
        end
        c_next_s = BITS'(clamp_or_wrap(SAT_W'(acc_next_s), BITS, SATURATE != 0));
    end

    // Stage 2: accumulate and, on the closing beat, capture the narrowed result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_r <= '0;
            c_r   <= '0;
        end else if (ctl.valid) begin
            acc_r <= acc_next_s;
            if (ctl.last) begin
                c_r <= c_next_s;
            end else begin
                c_r <= c_r;
            end
        end else begin
            acc_r <= acc_r;
            c_r   <= c_r;
        end
    end

    assign c_row = c_r;

endmodule

// File: rtl/fixed_integer_matrix_dot_vector.sv
// Streaming matrix-by-vector product: NEURONS stored weight rows dotted with an input
// vector that arrives MULTS elements per beat.
// Ports:
//   clk, rstn   : clock and asynchronous active-low reset
//   in_valid    : vector_b carries a beat
//   load_a      : vector_a_in carries a weight beat (wins over in_valid, aborts a partial vector)
//   vector_a_in : MULTS weight words, word m at [m*BITS +: BITS]
//   vector_b    : MULTS input words, word m at [m*BITS +: BITS]
//   out_valid   : one-cycle strobe when c is updated
//   c           : row r result at [r*BITS +: BITS]
module fixed_integer_matrix_dot_vector
    import fixed_integer_nn_pkg::*;
#(
    parameter int BITS     = 16,
    parameter int LENGTH   = 10,
    parameter int MULTS    = 2,
    parameter int NEURONS  = 4,
    parameter int SATURATE = 0
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      in_valid,
    input  logic                      load_a,
    input  logic [BITS*MULTS-1:0]     vector_a_in,
    input  logic [BITS*MULTS-1:0]     vector_b,
    output logic                      out_valid,
    output logic [BITS*NEURONS-1:0]   c
);

    localparam int BEATS     = LENGTH / MULTS;
    localparam int CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BEAT_BITS = MULTS * BITS;
    localparam int W_BITS    = NEURONS * LENGTH * BITS;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    logic [W_BITS-1:0] weights_r;
    logic [CNT_W-1:0]  cnt_r;
    beat_ctl_t         s1_ctl_r;
    logic              out_valid_r;
    logic              accept_s;

    assign accept_s = in_valid & ~load_a;

    // Weight shift store: each load beat moves everything up by MULTS words and
    // places the new words at flat indices 0..MULTS-1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            weights_r <= '0;
        end else if (load_a) begin
            weights_r <= (weights_r << BEAT_BITS) | W_BITS'(vector_a_in);
        end else begin
            weights_r <= weights_r;
        end
    end

    // Beat counter and stage-1 tag; a load beat drops any concurrent in_valid beat and
    // restarts the vector so the next accepted beat is a first beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r    <= '0;
            s1_ctl_r <= '0;
        end else if (load_a) begin
            cnt_r    <= '0;
            s1_ctl_r <= '0;
        end else if (in_valid) begin
            s1_ctl_r.valid <= 1'b1;
            s1_ctl_r.first <= (cnt_r == '0);
            s1_ctl_r.last  <= (cnt_r == LAST_CNT);
            cnt_r          <= (cnt_r == LAST_CNT) ? '0 : cnt_r + CNT_W'(1);
        end else begin
            cnt_r    <= cnt_r;
            s1_ctl_r <= '0;
        end
    end

    // Result strobe follows the stage-2 capture of a closing beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= s1_ctl_r.valid & s1_ctl_r.last;
        end
    end

    assign out_valid = out_valid_r;

    for (genvar r = 0; r < NEURONS; r++) begin : g_row
        integer_mac_row #(
            .BITS     (BITS),
            .LENGTH   (LENGTH),
            .MULTS    (MULTS),
            .SATURATE (SATURATE),
            .CNT_W    (CNT_W)
        ) u_row (
            .clk         (clk),
            .rstn        (rstn),
            .accept      (accept_s),
            .beat_idx    (cnt_r),
            .ctl         (s1_ctl_r),
            .row_weights (weights_r[r*LENGTH*BITS +: LENGTH*BITS]),
            .vector_b    (vector_b),
            .c_row       (c[r*BITS +: BITS])
        );
    end

endmodule

// File: tb/tb_fixed_integer_matrix_dot_vector.sv
// Self-checking bench: directed scenarios plus random traffic, checked against a
// behavioural model (weight store + per-vector dot products with plain arithmetic).
module tb_fixed_integer_matrix_dot_vector;

    localparam int BITS    = 16;
    localparam int LENGTH  = 4;
    localparam int MULTS   = 2;
    localparam int NEURONS = 2;
    localparam int NW      = NEURONS * LENGTH;
    localparam int N_LOAD  = NW / MULTS;

    logic                    clk;
    logic                    rstn;
    logic                    in_valid;
    logic                    load_a;
    logic [BITS*MULTS-1:0]   vector_a_in;
    logic [BITS*MULTS-1:0]   vector_b;
    logic                    ov_w;
    logic                    ov_s;
    logic [BITS*NEURONS-1:0] c_w;
    logic [BITS*NEURONS-1:0] c_s;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    longint          wm [NW];
    longint          vb [LENGTH];
    int              mcnt;
    bit              pend_ov;
    bit              exp_ov;
    logic [BITS-1:0] pend_w [NEURONS];
    logic [BITS-1:0] pend_s [NEURONS];
    logic [BITS-1:0] exp_w  [NEURONS];
    logic [BITS-1:0] exp_s  [NEURONS];

    fixed_integer_matrix_dot_vector #(
        .BITS(BITS), .LENGTH(LENGTH), .MULTS(MULTS), .NEURONS(NEURONS), .SATURATE(0)
    ) dut_wrap (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .load_a(load_a),
        .vector_a_in(vector_a_in), .vector_b(vector_b), .out_valid(ov_w), .c(c_w)
    );

    fixed_integer_matrix_dot_vector #(
        .BITS(BITS), .LENGTH(LENGTH), .MULTS(MULTS), .NEURONS(NEURONS), .SATURATE(1)
    ) dut_sat (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .load_a(load_a),
        .vector_a_in(vector_a_in), .vector_b(vector_b), .out_valid(ov_s), .c(c_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [BITS-1:0] sat16(input longint v);
        logic [63:0] t;
        t = v;
        if (v > 32767) return 16'h7fff;
        else if (v < -32768) return 16'h8000;
        else return t[BITS-1:0];
    endfunction

    function automatic logic [BITS-1:0] wrap16(input longint v);
        logic [63:0] t;
        t = v;
        return t[BITS-1:0];
    endfunction

    function automatic longint rnd_word();
        logic [BITS-1:0] t;
        if ($urandom_range(0, 1) == 0) begin
            t = 16'($urandom);
        end else begin
            t = 16'($signed(32'($urandom_range(0, 200)) - 32'd100));
        end
        return longint'($signed(t));
    endfunction

    function automatic logic [BITS-1:0] row_of(input logic [BITS*NEURONS-1:0] v, input int r);
        return v[r*BITS +: BITS];
    endfunction

    // One clock cycle: drive at the falling edge, update the model at the rising edge,
    // compare every output just after it.
    task automatic step(input bit ld, input longint a0, input longint a1,
                        input bit iv, input longint b0, input longint b1);
        longint sum;
        load_a      = ld;
        in_valid    = iv;
        vector_a_in = {16'(a1), 16'(a0)};
        vector_b    = {16'(b1), 16'(b0)};
        @(posedge clk);
        #1;
        exp_ov = pend_ov;
        if (pend_ov) begin
            for (int r = 0; r < NEURONS; r++) begin
                exp_w[r] = pend_w[r];
                exp_s[r] = pend_s[r];
            end
        end
        pend_ov = 1'b0;
        if (ld) begin
            for (int i = NW - 1; i >= MULTS; i--) wm[i] = wm[i-MULTS];
            wm[0] = a0;
            wm[1] = a1;
            mcnt  = 0;
        end else if (iv) begin
            vb[mcnt*MULTS]     = b0;
            vb[mcnt*MULTS + 1] = b1;
            mcnt++;
            if (mcnt == LENGTH / MULTS) begin
                mcnt = 0;
                for (int r = 0; r < NEURONS; r++) begin
                    sum = 0;
                    for (int e = 0; e < LENGTH; e++) sum += wm[r*LENGTH + e] * vb[e];
                    pend_w[r] = wrap16(sum);
                    pend_s[r] = sat16(sum);
                end
                pend_ov = 1'b1;
            end
        end
        chk("out_valid_wrap", 64'(ov_w), 64'(exp_ov));
        chk("out_valid_sat", 64'(ov_s), 64'(exp_ov));
        for (int r = 0; r < NEURONS; r++) begin
            chk($sformatf("c_wrap[%0d]", r), 64'(row_of(c_w, r)), 64'(exp_w[r]));
            chk($sformatf("c_sat[%0d]", r), 64'(row_of(c_s, r)), 64'(exp_s[r]));
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 1'b0, 0, 0);
    endtask

    task automatic beat(input longint b0, input longint b1);
        step(1'b0, 0, 0, 1'b1, b0, b1);
    endtask

    // Load a full weight matrix (flat index = row*LENGTH + element); beat j lands at
    // flat indices (N_LOAD-1-j)*MULTS + m once all beats are in.
    task automatic load_rows(input longint w [NW]);
        for (int j = 0; j < N_LOAD; j++) begin
            step(1'b1, w[(N_LOAD-1-j)*MULTS], w[(N_LOAD-1-j)*MULTS + 1], 1'b0, 0, 0);
        end
    endtask

    // Asynchronous reset pulse between clock edges; outputs are checked with no edge seen.
    task automatic pulse_reset();
        in_valid = 1'b0;
        load_a   = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("rst_out_valid_wrap", 64'(ov_w), 64'd0);
        chk("rst_out_valid_sat", 64'(ov_s), 64'd0);
        chk("rst_c_wrap", 64'(c_w), 64'd0);
        chk("rst_c_sat", 64'(c_s), 64'd0);
        for (int i = 0; i < NW; i++) wm[i] = 0;
        for (int r = 0; r < NEURONS; r++) begin
            exp_w[r] = '0;
            exp_s[r] = '0;
        end
        mcnt    = 0;
        pend_ov = 1'b0;
        exp_ov  = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    longint w_basic [NW];
    longint w_max   [NW];
    int     sel;

    initial begin
        rstn        = 1'b1;
        in_valid    = 1'b0;
        load_a      = 1'b0;
        vector_a_in = '0;
        vector_b    = '0;
        for (int i = 0; i < NW; i++) wm[i] = 0;
        for (int r = 0; r < NEURONS; r++) begin
            exp_w[r] = '0; exp_s[r] = '0; pend_w[r] = '0; pend_s[r] = '0;
        end
        mcnt = 0; pend_ov = 1'b0; exp_ov = 1'b0;
        w_basic = '{1, 2, 3, 4, -1, 0, 1, 2};
        for (int i = 0; i < NW; i++) w_max[i] = 32767;

        // Reset state before any clock edge
        pulse_reset();

        // Basic vector
        load_rows(w_basic);
        beat(5, 6);
        beat(7, 8);
        idle();
        chk("basic_strobe", 64'(ov_w), 64'd1);
        chk("basic_c0", 64'(row_of(c_w, 0)), 64'd70);
        chk("basic_c1", 64'(row_of(c_w, 1)), 64'd18);
        idle();
        chk("basic_strobe_one_cycle", 64'(ov_w), 64'd0);
        chk("basic_c0_held", 64'(row_of(c_w, 0)), 64'd70);

        // Back-to-back vectors
        beat(5, 6);
        beat(7, 8);
        beat(1, 1);
        chk("b2b_strobe1", 64'(ov_w), 64'd1);
        chk("b2b_v1_c0", 64'(row_of(c_w, 0)), 64'd70);
        beat(1, 1);
        chk("b2b_gap", 64'(ov_w), 64'd0);
        idle();
        chk("b2b_strobe2", 64'(ov_w), 64'd1);
        chk("b2b_v2_c0", 64'(row_of(c_w, 0)), 64'd10);
        chk("b2b_v2_c1", 64'(row_of(c_w, 1)), 64'd2);
        idle();

        // Abort by load: the in_valid beat alongside load_a is dropped
        beat(5, 6);
        step(1'b1, 9, 9, 1'b1, 7, 8);
        idle();
        beat(1, 1);
        chk("abort_no_strobe", 64'(ov_w), 64'd0);
        beat(1, 1);
        idle();
        chk("abort_restart_strobe", 64'(ov_w), 64'd1);
        chk("abort_c0", 64'(row_of(c_w, 0)), 64'd21);
        chk("abort_c1", 64'(row_of(c_w, 1)), 64'd6);

        // Overflow: saturate vs wrap
        load_rows(w_max);
        beat(32767, 32767);
        beat(32767, 32767);
        idle();
        chk("ovf_sat_c0", 64'(row_of(c_s, 0)), 64'd32767);
        chk("ovf_sat_c1", 64'(row_of(c_s, 1)), 64'd32767);
        chk("ovf_wrap_c0", 64'(row_of(c_w, 0)), 64'd4);
        chk("ovf_wrap_c1", 64'(row_of(c_w, 1)), 64'd4);
        idle();

        // Reset mid-vector: no strobe, weights cleared
        load_rows(w_basic);
        beat(5, 6);
        pulse_reset();
        idle();
        chk("midrst_no_strobe", 64'(ov_w), 64'd0);
        beat(5, 6);
        beat(7, 8);
        idle();
        chk("midrst_strobe", 64'(ov_w), 64'd1);
        chk("midrst_zero_weights", 64'(c_w), 64'd0);

        // Random traffic
        load_rows(w_basic);
        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 19);
            if (sel == 0) begin
                pulse_reset();
            end else if (sel <= 3) begin
                step(1'b1, rnd_word(), rnd_word(), 1'($urandom_range(0, 1)), rnd_word(), rnd_word());
            end else if (sel <= 6) begin
                idle();
            end else begin
                beat(rnd_word(), rnd_word());
            end
        end
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
